// File: rtl/rr_mux_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : rr_mux_sequencer
//  Purpose  : Round-robin sequencer in front of a combinational 4:1 N-bit
//             channel mux. It arbitrates four level-held requests and drives
//             a registered 2-bit select. After the mux has settled, it
//             captures the mux output into a valid/ready output register
//             and pulses a one-cycle acknowledge to the serviced channel.
//  Revision : 1.0  initial release
// ============================================================================
module rr_mux_sequencer #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   REQ,
  output logic [1:0]   S,
  input  logic [N-1:0] Y,
  output logic [3:0]   ACK,
  output logic [N-1:0] DOUT,
  output logic         DOUT_VALID,
  input  logic         DOUT_READY
);

  // Sequencer phases: IDLE arbitrates, CAPTURE samples the settled mux output,
  // HOLD keeps the captured word until the downstream side takes it.
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;

  // Channel most recently serviced. The scan for the next winner starts just
  // after it, which gives rotating priority.
  logic [1:0] last;
  logic [1:0] winner;
  logic [1:0] cand;
  logic       found;

  logic       req_hit;
  logic       accept;
  logic [3:0] ack_onehot;

  // The selected channel is still requesting. REQ is indexed by the
  // registered select that the mux is currently steering.
  assign req_hit    = REQ[S];
  assign accept     = DOUT_VALID && DOUT_READY;
  assign ack_onehot = 4'b0001 << S;

  // Rotating-priority scan: last+1, last+2, last+3, last (mod 4).
  always_comb begin
    winner = last;
    found  = 1'b0;
    cand   = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand = last + 2'(i);
      if (!found && REQ[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Next-state decision. An active transfer is never preempted; requests
  // arriving during CAPTURE or HOLD wait for the next IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (|REQ) begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        state_nxt = req_hit ? HOLD : IDLE;
      end
      HOLD: begin
        if (accept) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register. Reset returns to IDLE from any phase and abandons the
  // transfer in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Mux select and priority pointer. S changes only on an IDLE decision, so
  // it is stable for the whole CAPTURE cycle. The pointer advances only when
  // a word is actually captured, so a withdrawn request leaves priority as it was.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      S    <= 2'b00;
      last <= 2'b11;
    end else begin
      if (state == IDLE && (|REQ)) begin
        S <= winner;
      end
      if (state == CAPTURE && req_hit) begin
        last <= S;
      end
    end
  end

  // Output stage: register the mux output. ACK pulses on the same edge that
  // raises DOUT_VALID. DOUT keeps its value after the handshake and is
  // cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      DOUT       <= '0;
      DOUT_VALID <= 1'b0;
      ACK        <= 4'b0000;
    end else begin
      ACK <= 4'b0000;
      if (state == CAPTURE && req_hit) begin
        DOUT       <= Y;
        DOUT_VALID <= 1'b1;
        ACK        <= ack_onehot;
      end else if (state == HOLD && accept) begin
        DOUT_VALID <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
